addr_decode_unit: RTL and testbench

Combinational 64 KiB address decoder for the 6502 system bus. It maps each 16-bit CPU address to at most one chip select: SDRAM, hex display, UART, board I/O, IRQ controller, or boot ROM. A small clocked fault monitor sits beside the decoder. It records CPU accesses that land in the unmapped I/O hole, for debug. The block sits between the CPU address bus and the peripheral/memory select inputs in the top level.

---
 rtl/addr_map_pkg.sv | 38 +++
 rtl/addr_decode_unit_if.sv | 29 ++
 rtl/addr_fault_mon.sv | 32 +++
 rtl/addr_decode_unit.sv | 66 ++++++
 tb/tb_addr_decode_unit.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/addr_map_pkg.sv
// Fixed 6502 system memory map: region bounds, region encoding and the address-to-region decode.
package addr_map_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COUNT_W = 8;

  localparam logic [ADDR_W-1:0] SDRAM_END     = 16'h7FEF;
  localparam logic [ADDR_W-1:0] HEX_BASE      = 16'h7FF0;
  localparam logic [ADDR_W-1:0] UART_BASE     = 16'h7FF4;
  localparam logic [ADDR_W-1:0] BOARD_IO_ADDR = 16'h7FF6;
  localparam logic [ADDR_W-1:0] IRQ_ADDR      = 16'h7FFF;
  localparam logic [ADDR_W-1:0] ROM_BASE      = 16'h8000;

  typedef enum logic [2:0] {
    REG_SDRAM,
    REG_HEX,
    REG_UART,
    REG_BOARD_IO,
    REG_IRQ,
    REG_ROM,
    REG_NONE
  } region_t;

  // Ordered compare chain; 0x7FF7..0x7FFE falls through to the I/O hole.
  function automatic region_t decode_region(input logic [ADDR_W-1:0] a);
    region_t r;
    if (a >= ROM_BASE)           r = REG_ROM;
    else if (a <= SDRAM_END)     r = REG_SDRAM;
    else if (a < HEX_BASE)       r = REG_NONE;
    else if (a < UART_BASE)      r = REG_HEX;
    else if (a < BOARD_IO_ADDR)  r = REG_UART;
    else if (a == BOARD_IO_ADDR) r = REG_BOARD_IO;
    else if (a == IRQ_ADDR)      r = REG_IRQ;
    else                         r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/addr_decode_unit_if.sv
// CPU-address-side bundle of the address decoder: address/access in, selects and fault monitor out.
interface addr_decode_unit_if;
  import addr_map_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic               access;
  logic               sdram_cs;
  logic               hex_cs;
  logic               uart_cs;
  logic               board_io_cs;
  logic               irq_cs;
  logic               rom_cs;
  logic               unmapped;
  logic               fault_valid;
  logic [ADDR_W-1:0]  fault_addr;
  logic [COUNT_W-1:0] fault_count;

  modport master (
    output addr, access,
    input  sdram_cs, hex_cs, uart_cs, board_io_cs, irq_cs, rom_cs, unmapped,
    input  fault_valid, fault_addr, fault_count
  );

  modport slave (
    input  addr, access,
    output sdram_cs, hex_cs, uart_cs, board_io_cs, irq_cs, rom_cs, unmapped,
    output fault_valid, fault_addr, fault_count
  );
endinterface

// File: rtl/addr_fault_mon.sv
// Records CPU accesses into the unmapped I/O hole: sticky flag, last address, saturating count.
module addr_fault_mon
  import addr_map_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               access,
  input  logic               unmapped,
  input  logic [ADDR_W-1:0]  addr,
  output logic               fault_valid,
  output logic [ADDR_W-1:0]  fault_addr,
  output logic [COUNT_W-1:0] fault_count
);

  logic event_c;
  assign event_c = access && unmapped;

  // Reset wins over a coincident event; count holds once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_count <= '0;
    end else if (event_c) begin
      fault_valid <= 1'b1;
      fault_addr  <= addr;
      if (fault_count != {COUNT_W{1'b1}})
        fault_count <= fault_count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/addr_decode_unit.sv
// 64 KiB 6502 address decoder with optional unmapped-access monitor.
// Monitor is built only when ADDR_DECODE_FAULT_MON_EN is defined; otherwise fault outputs are tied to 0.
module addr_decode_unit
  import addr_map_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  addr_decode_unit_if.slave  bus
);

  region_t region_c;

  always_comb begin
    region_c = decode_region(bus.addr);
  end

  // One-hot expansion of the region; selects depend on addr only.
  always_comb begin
    bus.sdram_cs    = 1'b0;
    bus.hex_cs      = 1'b0;
    bus.uart_cs     = 1'b0;
    bus.board_io_cs = 1'b0;
    bus.irq_cs      = 1'b0;
    bus.rom_cs      = 1'b0;
    bus.unmapped    = 1'b0;
    case (region_c)
      REG_SDRAM:    bus.sdram_cs    = 1'b1;
      REG_HEX:      bus.hex_cs      = 1'b1;
      REG_UART:     bus.uart_cs     = 1'b1;
      REG_BOARD_IO: bus.board_io_cs = 1'b1;
      REG_IRQ:      bus.irq_cs      = 1'b1;
      REG_ROM:      bus.rom_cs      = 1'b1;
      default:      bus.unmapped    = 1'b1;
    endcase
  end

`ifdef ADDR_DECODE_FAULT_MON_EN
  logic               fault_valid;
  logic [ADDR_W-1:0]  fault_addr;
  logic [COUNT_W-1:0] fault_count;

  addr_fault_mon u_fault_mon (
    .clk         (clk),
    .rst_n       (rst_n),
    .access      (bus.access),
    .unmapped    (bus.unmapped),
    .addr        (bus.addr),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_count (fault_count)
  );

  assign bus.fault_valid = fault_valid;
  assign bus.fault_addr  = fault_addr;
  assign bus.fault_count = fault_count;
`else
  // Ports stay present for a uniform top level; their inputs are intentionally unused here.
  logic unused_mon_inputs;
  assign unused_mon_inputs = &{1'b0, clk, rst_n, bus.access};

  assign bus.fault_valid = 1'b0;
  assign bus.fault_addr  = '0;
  assign bus.fault_count = '0;
`endif

endmodule

// File: tb/tb_addr_decode_unit.sv
// Directed self-checking bench for addr_decode_unit: full address sweeps, boundary table and monitor sequences.
module tb_addr_decode_unit;

`ifdef ADDR_DECODE_FAULT_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  addr_decode_unit_if bus ();

  addr_decode_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference map, written from the literal bounds: {sdram,hex,uart,board_io,irq,rom,unmapped}.
  function automatic logic [6:0] ref_sel(input int a);
    if (a <= 32'h7FEF)       return 7'b1000000;
    else if (a <= 32'h7FF3)  return 7'b0100000;
    else if (a <= 32'h7FF5)  return 7'b0010000;
    else if (a == 32'h7FF6)  return 7'b0001000;
    else if (a <= 32'h7FFE)  return 7'b0000001;
    else if (a == 32'h7FFF)  return 7'b0000100;
    else                     return 7'b0000010;
  endfunction

  function automatic logic [6:0] obs_sel();
    return {bus.sdram_cs, bus.hex_cs, bus.uart_cs, bus.board_io_cs,
            bus.irq_cs, bus.rom_cs, bus.unmapped};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag, input int a, input logic [6:0] exp);
    bus.addr = 16'(a);
    #1;
    tests_run++;
    assert (obs_sel() === exp)
    else begin
      tests_failed++;
      $error("FAIL %s addr=%h observed=%b expected=%b", tag, 16'(a), obs_sel(), exp);
    end
  endtask

  // Monitor expectations collapse to zero when the monitor is not built.
  task automatic chk_mon(input string tag, input logic v, input logic [15:0] a, input logic [7:0] c);
    chk({tag, "_valid"}, 32'(bus.fault_valid), MON ? 32'(v) : 32'd0);
    chk({tag, "_addr"},  32'(bus.fault_addr),  MON ? 32'(a) : 32'd0);
    chk({tag, "_count"}, 32'(bus.fault_count), MON ? 32'(c) : 32'd0);
  endtask

  // Drive one cycle at the falling edge and leave the bench just after the next falling edge.
  task automatic cycle(input logic [15:0] a, input logic acc);
    bus.addr   = a;
    bus.access = acc;
    @(posedge clk);
    @(negedge clk);
    bus.access = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.addr     = 16'h0000;
    bus.access   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_mon("reset", 1'b0, 16'h0000, 8'h00);

    // Sweep under reset with access=1: decode unaffected, monitor held clear.
    bus.access = 1'b1;
    for (int a = 0; a < 65536; a++) chk_sel("sweep_rst", a, ref_sel(a));
    bus.access = 1'b0;
    @(negedge clk);
    chk_mon("after_rst_sweep", 1'b0, 16'h0000, 8'h00);

    rst_n = 1'b1;
    for (int a = 0; a < 65536; a++) chk_sel("sweep", a, ref_sel(a));
    @(negedge clk);
    chk_mon("access0_sweep", 1'b0, 16'h0000, 8'h00);

    // Region boundaries with hand-written expectations.
    chk_sel("b_7fef", 32'h7FEF, 7'b1000000);
    chk_sel("b_7ff0", 32'h7FF0, 7'b0100000);
    chk_sel("b_7ff3", 32'h7FF3, 7'b0100000);
    chk_sel("b_7ff4", 32'h7FF4, 7'b0010000);
    chk_sel("b_7ff5", 32'h7FF5, 7'b0010000);
    chk_sel("b_7ff6", 32'h7FF6, 7'b0001000);
    chk_sel("b_7ff7", 32'h7FF7, 7'b0000001);
    chk_sel("b_7ffe", 32'h7FFE, 7'b0000001);
    chk_sel("b_7fff", 32'h7FFF, 7'b0000100);
    chk_sel("b_8000", 32'h8000, 7'b0000010);
    chk_sel("b_ffff", 32'hFFFF, 7'b0000010);
    chk_sel("b_0000", 32'h0000, 7'b1000000);

    @(negedge clk);
    cycle(16'h7FF9, 1'b1);
    chk_mon("first_event", 1'b1, 16'h7FF9, 8'h01);

    cycle(16'h7FFF, 1'b1);
    cycle(16'h7FF6, 1'b1);
    cycle(16'h1234, 1'b1);
    chk_mon("mapped_access", 1'b1, 16'h7FF9, 8'h01);

    cycle(16'h7FFB, 1'b0);
    chk_mon("hole_no_access", 1'b1, 16'h7FF9, 8'h01);

    // 300 back-to-back events at 0x7FFA, checked just before saturation.
    bus.addr   = 16'h7FFA;
    bus.access = 1'b1;
    repeat (253) @(posedge clk);
    @(negedge clk);
    chk_mon("pre_sat", 1'b1, 16'h7FFA, 8'hFE);
    repeat (47) @(posedge clk);
    @(negedge clk);
    chk_mon("sat", 1'b1, 16'h7FFA, 8'hFF);
    cycle(16'h7FF7, 1'b1);
    chk_mon("sat_last", 1'b1, 16'h7FF7, 8'hFF);

    // Reset coincident with an event clears the monitor.
    rst_n = 1'b0;
    cycle(16'h7FFE, 1'b1);
    chk_mon("rst_event", 1'b0, 16'h0000, 8'h00);
    chk("rst_decode", 32'(obs_sel()), 32'(7'b0000001));

    rst_n = 1'b1;
    cycle(16'h7FF8, 1'b1);
    chk_mon("post_rst_event", 1'b1, 16'h7FF8, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
